// File: rtl/ram_4x8_arbiter.sv
// ram_4x8_arbiter: round-robin two-client arbiter serialising IDLE->ACCESS->DONE accesses to one ram_4x8.
// Optional RAM_ARB_SCRUB_EN: zero-fill the RAM after every reset before accepting requests.
module ram_4x8_arbiter #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              req_a,
   input  logic              rw_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic              ack_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              req_b,
   input  logic              rw_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              ack_b,
   output logic [DATA_W-1:0] rdata_b,
   output logic              ready,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_read_write,
   output logic [DATA_W-1:0] ram_data,
   input  logic [DATA_W-1:0] ram_q
);
   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
`ifdef RAM_ARB_SCRUB_EN
      , INIT
`endif
   } state_e;
`ifdef RAM_ARB_SCRUB_EN
   localparam state_e RST_STATE = INIT;
   localparam logic   RST_READY = 1'b0;
`else
   localparam state_e RST_STATE = IDLE;
   localparam logic   RST_READY = 1'b1;
`endif
   state_e            state_q;
   logic              grant_b_q, last_b_q, ack_a_q, ack_b_q, ready_q, ram_rw_q;
   logic [DATA_W-1:0] rdata_a_q, rdata_b_q, ram_data_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic              grant_b_d;
   // B wins when alone, or on a tie when A was served last
   always_comb grant_b_d = req_b & (~req_a | ~last_b_q);
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q    <= RST_STATE;
         grant_b_q  <= 1'b0;
         last_b_q   <= 1'b1;
         ack_a_q    <= 1'b0;
         ack_b_q    <= 1'b0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
         ready_q    <= RST_READY;
         ram_addr_q <= '0;
         ram_rw_q   <= 1'b0;
         ram_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (req_a | req_b) begin
               grant_b_q  <= grant_b_d;
               ram_addr_q <= grant_b_d ? addr_b : addr_a;
               ram_rw_q   <= grant_b_d ? rw_b : rw_a;
               ram_data_q <= grant_b_d ? wdata_b : wdata_a;
               state_q    <= ACCESS;
            end
            ACCESS: begin
               if (!ram_rw_q && grant_b_q) rdata_b_q <= ram_q;
               if (!ram_rw_q && !grant_b_q) rdata_a_q <= ram_q;
               ack_a_q  <= ~grant_b_q;
               ack_b_q  <= grant_b_q;
               ram_rw_q <= 1'b0;
               state_q  <= DONE;
            end
            DONE: begin
               ack_a_q  <= 1'b0;
               ack_b_q  <= 1'b0;
               last_b_q <= grant_b_q;
               state_q  <= IDLE;
            end
`ifdef RAM_ARB_SCRUB_EN
            // ram_rw_q low marks the first INIT cycle after reset release
            INIT: if (!ram_rw_q) begin
               ram_rw_q   <= 1'b1;
               ram_addr_q <= '0;
               ram_data_q <= '0;
            end else if (&ram_addr_q) begin
               ram_rw_q <= 1'b0;
               ready_q  <= 1'b1;
               state_q  <= IDLE;
            end else begin
               ram_addr_q <= ram_addr_q + ADDR_W'(1);
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end
   assign ack_a          = ack_a_q;
   assign ack_b          = ack_b_q;
   assign rdata_a        = rdata_a_q;
   assign rdata_b        = rdata_b_q;
   assign ready          = ready_q;
   assign ram_address    = ram_addr_q;
   assign ram_read_write = ram_rw_q;
   assign ram_data       = ram_data_q;
endmodule

// File: tb/tb_ram_4x8_arbiter.sv
// tb_ram_4x8_arbiter: directed bench for ram_4x8_arbiter with a behavioural ram_4x8 and an ack scoreboard.
module tb_ram_4x8_arbiter;
   typedef struct packed {
      logic       b;
      logic       rd;
      logic [7:0] d;
   } exp_t;
   logic       clock = 1'b0;
   logic       clear;
   logic       req_a, rw_a, ack_a, req_b, rw_b, ack_b;
   logic [1:0] addr_a, addr_b, ram_address;
   logic [7:0] wdata_a, rdata_a, wdata_b, rdata_b, ram_data, ram_q;
   logic       ready, ram_read_write;
   logic [7:0] mem [4];
   logic [7:0] exp_mem [4];
   logic       fill;
   logic [7:0] fill_val;
   exp_t       sb[$];
   exp_t       mon_e;
   int         tests = 0;
   int         fails = 0;
   int         ta, tbt, na, nb, rdy0, strobes;
   always #5 clock = ~clock;
   ram_4x8_arbiter dut (
      .clock(clock), .clear(clear),
      .req_a(req_a), .rw_a(rw_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
      .req_b(req_b), .rw_b(rw_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
      .ready(ready), .ram_address(ram_address), .ram_read_write(ram_read_write),
      .ram_data(ram_data), .ram_q(ram_q)
   );
   always @(posedge clock)
      if (fill) for (int i = 0; i < 4; i++) mem[i] <= fill_val;
      else if (ram_read_write) mem[ram_address] <= ram_data;
   assign ram_q = mem[ram_address];
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // scoreboard: every ack must match the oldest outstanding expectation
   always @(negedge clock)
      if (clear === 1'b1 && (ack_a || ack_b)) begin
         if (sb.size() == 0) chk("spurious_ack", {ack_b, ack_a}, 2'b00);
         else begin
            mon_e = sb.pop_front();
            chk("ack_client", {ack_b, ack_a}, mon_e.b ? 2'b10 : 2'b01);
            if (mon_e.rd) chk("rdata", mon_e.b ? rdata_b : rdata_a, mon_e.d);
         end
      end
   task automatic wait_ready();
      for (int n = 0; n < 10 && ready !== 1'b1; n++) @(negedge clock);
      chk("ready", ready, 1'b1);
   endtask
   task automatic do_reset();
      @(negedge clock);
      clear = 1'b0;
      req_a = 1'b0;
      req_b = 1'b0;
      @(negedge clock);
      clear = 1'b1;
      wait_ready();
   endtask
   task automatic push(input logic b, input logic w, input logic [1:0] a, input logic [7:0] d);
      exp_t e;
      e.b  = b;
      e.rd = ~w;
      e.d  = w ? d : exp_mem[a];
      sb.push_back(e);
      if (w) exp_mem[a] = d;
   endtask
   task automatic access(input logic b, input logic w, input logic [1:0] a, input logic [7:0] d);
      int lat;
      push(b, w, a, d);
      if (b) begin req_b = 1'b1; rw_b = w; addr_b = a; wdata_b = d; end
      else begin req_a = 1'b1; rw_a = w; addr_a = a; wdata_a = d; end
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
         if (lat == 1) begin
            chk("strobe_rw", ram_read_write, w);
            chk("strobe_addr", ram_address, a);
            if (w) chk("strobe_data", ram_data, d);
         end
      end while (!(b ? ack_b : ack_a) && lat < 10);
      chk("latency", lat, 2);
      chk("other_ack", b ? ack_a : ack_b, 1'b0);
      chk("strobe_off", ram_read_write, 1'b0);
      req_a = 1'b0;
      req_b = 1'b0;
      @(negedge clock);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      clear = 1'b0;
      {req_a, rw_a, addr_a, wdata_a, req_b, rw_b, addr_b, wdata_b} = '0;
      fill = 1'b1;
      fill_val = 8'h00;
      for (int i = 0; i < 4; i++) exp_mem[i] = 8'h00;
      repeat (2) @(negedge clock);
      fill = 1'b0;
      chk("rst_acks", {ack_a, ack_b}, 2'b00);
      chk("rst_rdata", {rdata_a, rdata_b}, 16'h0000);
      chk("rst_ram", {ram_address, ram_read_write, ram_data}, 11'h000);
`ifdef RAM_ARB_SCRUB_EN
      chk("rst_ready", ready, 1'b0);
`else
      chk("rst_ready", ready, 1'b1);
`endif
      clear = 1'b1;
      wait_ready();
      // single write from A, then read-back from B
      access(1'b0, 1'b1, 2'd2, 8'hA5);
      access(1'b1, 1'b0, 2'd2, 8'h00);
      chk("rdata_a_hold", rdata_a, 8'h00);
      chk("rdata_b_val", rdata_b, 8'hA5);
      // simultaneous writes after reset: A first, B three cycles later
      do_reset();
      push(1'b0, 1'b1, 2'd1, 8'h11);
      push(1'b1, 1'b1, 2'd1, 8'h22);
      req_a = 1'b1; rw_a = 1'b1; addr_a = 2'd1; wdata_a = 8'h11;
      req_b = 1'b1; rw_b = 1'b1; addr_b = 2'd1; wdata_b = 8'h22;
      ta = -1;
      tbt = -1;
      for (int c = 1; c <= 12 && tbt < 0; c++) begin
         @(negedge clock);
         if (ack_a) begin ta = c; req_a = 1'b0; end
         if (ack_b) begin tbt = c; req_b = 1'b0; end
      end
      chk("tie_first_a", ta, 2);
      chk("tie_gap", tbt - ta, 3);
      @(negedge clock);
      access(1'b0, 1'b0, 2'd1, 8'h00);
      chk("tie_final", rdata_a, 8'h22);
      // continuous contention: grants alternate A,B,A,B
      do_reset();
      push(1'b0, 1'b1, 2'd0, 8'hC0);
      push(1'b1, 1'b1, 2'd1, 8'hD1);
      push(1'b0, 1'b1, 2'd0, 8'hC1);
      push(1'b1, 1'b1, 2'd1, 8'hD2);
      req_a = 1'b1; rw_a = 1'b1; addr_a = 2'd0; wdata_a = 8'hC0;
      req_b = 1'b1; rw_b = 1'b1; addr_b = 2'd1; wdata_b = 8'hD1;
      ta = 0;
      tbt = 0;
      na = 0;
      nb = 0;
      for (int c = 1; c <= 16 && na + nb < 4; c++) begin
         @(negedge clock);
         if (ack_a) begin
            na++;
            chk("gap_a", (c - ta) <= 6, 1'b1);
            ta = c;
            req_a = 1'b0;
            wdata_a = wdata_a + 8'd1;
         end else req_a = (na < 2);
         if (ack_b) begin
            nb++;
            chk("gap_b", (c - tbt) <= 6, 1'b1);
            tbt = c;
            req_b = 1'b0;
            wdata_b = wdata_b + 8'd1;
         end else req_b = (nb < 2);
      end
      chk("contention_acks", na + nb, 4);
      chk("contention_span", (ta > tbt ? ta : tbt) <= 12, 1'b1);
      req_a = 1'b0;
      req_b = 1'b0;
      @(negedge clock);
      access(1'b1, 1'b0, 2'd0, 8'h00);
      access(1'b0, 1'b0, 2'd1, 8'h00);
      // reset during ACCESS aborts the write and suppresses the ack
      access(1'b0, 1'b1, 2'd3, 8'h00);
      req_a = 1'b1; rw_a = 1'b1; addr_a = 2'd3; wdata_a = 8'hFF;
      @(negedge clock);
      chk("abort_strobe", ram_read_write, 1'b1);
      clear = 1'b0;
      req_a = 1'b0;
      #1;
      chk("abort_ram", {ram_address, ram_read_write, ram_data}, 11'h000);
      chk("abort_acks", {ack_a, ack_b}, 2'b00);
      @(negedge clock);
      chk("abort_no_ack", {ack_a, ack_b}, 2'b00);
      clear = 1'b1;
      wait_ready();
      access(1'b1, 1'b0, 2'd3, 8'h00);
      chk("abort_content", rdata_b, 8'h00);
      chk("queue_empty", sb.size(), 0);
`ifdef RAM_ARB_SCRUB_EN
      // scrub after reset zero-fills a preloaded RAM
      fill = 1'b1;
      fill_val = 8'h5A;
      @(negedge clock);
      fill = 1'b0;
      clear = 1'b0;
      @(negedge clock);
      rdy0 = 0;
      strobes = 0;
      for (int c = 0; c < 8; c++) begin
         if (ready !== 1'b1) rdy0++;
         if (ram_read_write) begin
            chk("scrub_addr", ram_address, strobes);
            strobes++;
         end
         if (c == 0) clear = 1'b1;
         @(negedge clock);
      end
      chk("scrub_ready_low", rdy0, 5);
      chk("scrub_strobes", strobes, 4);
      for (int i = 0; i < 4; i++) exp_mem[i] = 8'h00;
      for (int i = 0; i < 4; i++) access(i[0], 1'b0, i[1:0], 8'h00);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
